riscv_mem: RTL and testbench

RISCV_MEM -- requirements
Module: riscv_MEM

---
 rtl/riscv_mem_pkg.sv | 58 +++++
 rtl/riscv_mem_load_ext.sv | 36 +++
 rtl/riscv_mem.sv | 181 ++++++++++++++++++
 tb/tb_riscv_mem.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_mem_pkg
//  Purpose  : Shared encodings for the MEM stage: rd-source selects, funct3
//             load/store codes, FSM states and byte-lane helper functions.
//  Revision : 1.0 - initial release
// ============================================================================
package riscv_mem_pkg;

    // Writeback source selects
    localparam logic [1:0] c_SRC_ALU  = 2'b00;
    localparam logic [1:0] c_SRC_LOAD = 2'b01;
    localparam logic [1:0] c_SRC_PC4  = 2'b10;
    localparam logic [1:0] c_SRC_IMM  = 2'b11;

    // funct3 access size / signedness
    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    // MEM stage FSM
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } mem_state_t;

    // Halfwords need bit 0 clear, words need both low bits clear.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] offset);
        logic r;
        r = 1'b0;
        if (funct3[1:0] == c_F3_H[1:0])
            r = offset[0];
        else if (funct3[1:0] == c_F3_W[1:0])
            r = (offset != 2'b00);
        return r;
    endfunction

    // Loads always fetch the full word; stores enable only the touched lanes.
    function automatic logic [3:0] byte_en(input logic [2:0] funct3,
                                           input logic       is_store,
                                           input logic [1:0] offset);
        logic [3:0] r;
        r = 4'b1111;
        if (is_store) begin
            if (funct3 == c_F3_B)
                r = 4'b0001 << offset;
            else if (funct3 == c_F3_H)
                r = 4'b0011 << {offset[1], 1'b0};
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_mem_load_ext.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_load_ext
//  Purpose  : Combinational load-data lane extraction with sign/zero
//             extension for LB/LH/LW/LBU/LHU.
//  Revision : 1.0 - initial release
// ============================================================================
module riscv_load_ext
    import riscv_mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rdata,
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_offset,
    output logic [XLEN-1:0] o_data
);

    // Addressed byte/halfword moved down to bit 0
    logic [15:0] w_lo;
    assign w_lo = 16'(i_rdata >> {i_offset, 3'b000});

    // Select width and extension from funct3; anything else passes the word
    always_comb begin
        o_data = i_rdata;
        case (i_funct3)
            c_F3_B:  o_data = {{(XLEN-8){w_lo[7]}}, w_lo[7:0]};
            c_F3_H:  o_data = {{(XLEN-16){w_lo[15]}}, w_lo};
            c_F3_BU: o_data = {{(XLEN-8){1'b0}}, w_lo[7:0]};
            c_F3_HU: o_data = {{(XLEN-16){1'b0}}, w_lo};
            default: o_data = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/riscv_mem.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_mem
//  Purpose  : RISC-V MEM pipeline stage. Passes ALU-type results through in
//             one cycle, runs loads/stores over a req/gnt/rvalid data-memory
//             port and flags misaligned accesses without touching memory.
//  Revision : 1.0 - initial release
// ============================================================================
module riscv_mem
    import riscv_mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_MEM_valid,
    output logic            o_MEM_ready,
    input  logic            i_MEM_reg_wr_en,
    input  logic [1:0]      i_MEM_src_rd,
    input  logic            i_MEM_mem_wr_en,
    input  logic [2:0]      i_MEM_funct3,
    input  logic [XLEN-1:0] i_MEM_alu_out,
    input  logic [XLEN-1:0] i_MEM_fwd_b,
    input  logic [XLEN-1:0] i_MEM_imm,
    input  logic [XLEN-1:0] i_MEM_pc4,
    input  logic [4:0]      i_MEM_rd,
    output logic            o_dmem_req,
    output logic            o_dmem_wr_en,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [XLEN-1:0] o_dmem_wdata,
    output logic [3:0]      o_dmem_be,
    input  logic            i_dmem_gnt,
    input  logic            i_dmem_rvalid,
    input  logic [XLEN-1:0] i_dmem_rdata,
    output logic            o_MEM_valid,
    output logic            o_MEM_reg_wr_en,
    output logic [4:0]      o_MEM_rd,
    output logic [XLEN-1:0] o_MEM_rd_data,
    output logic            o_MEM_misalign,
    output logic            o_MEM_stall
);

    mem_state_t      r_state;
    logic            r_reg_wr_en;
    logic            r_mem_wr_en;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_alu_out;
    logic [XLEN-1:0] r_fwd_b;
    logic [4:0]      r_rd;

    logic            r_valid;
    logic            r_wb_wr_en;
    logic [4:0]      r_wb_rd;
    logic [XLEN-1:0] r_wb_data;
    logic            r_misalign;

    logic            w_accept;
    logic            w_is_mem;
    logic            w_misalign;
    logic [XLEN-1:0] w_nonmem_data;
    logic [XLEN-1:0] w_load_data;
    logic [XLEN-1:0] w_wdata;

    assign w_accept   = i_MEM_valid && (r_state == S_IDLE);
    assign w_is_mem   = (i_MEM_src_rd == c_SRC_LOAD) || i_MEM_mem_wr_en;
    assign w_misalign = is_misaligned(i_MEM_funct3, i_MEM_alu_out[1:0]);

    // Writeback value for non-memory ops, chosen from the incoming operands
    always_comb begin
        w_nonmem_data = i_MEM_alu_out;
        case (i_MEM_src_rd)
            c_SRC_PC4: w_nonmem_data = i_MEM_pc4;
            c_SRC_IMM: w_nonmem_data = i_MEM_imm;
            default:   w_nonmem_data = i_MEM_alu_out;
        endcase
    end

    // Store data replicated into every lane so the byte enables pick it out
    always_comb begin
        w_wdata = r_fwd_b;
        case (r_funct3[1:0])
            2'b00:   w_wdata = {(XLEN/8){r_fwd_b[7:0]}};
            2'b01:   w_wdata = {(XLEN/16){r_fwd_b[15:0]}};
            default: w_wdata = r_fwd_b;
        endcase
    end

    riscv_load_ext #(
        .XLEN (XLEN)
    ) u_load_ext (
        .i_rdata  (i_dmem_rdata),
        .i_funct3 (r_funct3),
        .i_offset (r_alu_out[1:0]),
        .o_data   (w_load_data)
    );

    // Stage FSM: capture on accept, sequence the memory handshake, pulse WB
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state     <= S_IDLE;
            r_reg_wr_en <= 1'b0;
            r_mem_wr_en <= 1'b0;
            r_funct3    <= 3'b000;
            r_alu_out   <= '0;
            r_fwd_b     <= '0;
            r_rd        <= 5'd0;
            r_valid     <= 1'b0;
            r_wb_wr_en  <= 1'b0;
            r_wb_rd     <= 5'd0;
            r_wb_data   <= '0;
            r_misalign  <= 1'b0;
        end else begin
            r_valid    <= 1'b0;
            r_misalign <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_reg_wr_en <= i_MEM_reg_wr_en;
                        r_mem_wr_en <= i_MEM_mem_wr_en;
                        r_funct3    <= i_MEM_funct3;
                        r_alu_out   <= i_MEM_alu_out;
                        r_fwd_b     <= i_MEM_fwd_b;
                        r_rd        <= i_MEM_rd;
                        if (!w_is_mem) begin
                            r_valid    <= 1'b1;
                            r_wb_wr_en <= i_MEM_reg_wr_en;
                            r_wb_rd    <= i_MEM_rd;
                            r_wb_data  <= w_nonmem_data;
                        end else if (w_misalign) begin
                            r_valid    <= 1'b1;
                            r_misalign <= 1'b1;
                            r_wb_wr_en <= 1'b0;
                            r_wb_rd    <= i_MEM_rd;
                            r_wb_data  <= i_MEM_alu_out;
                        end else begin
                            r_state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (i_dmem_gnt) begin
                        if (r_mem_wr_en) begin
                            r_state    <= S_IDLE;
                            r_valid    <= 1'b1;
                            r_wb_wr_en <= 1'b0;
                            r_wb_rd    <= r_rd;
                            r_wb_data  <= r_alu_out;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (i_dmem_rvalid) begin
                        r_state    <= S_IDLE;
                        r_valid    <= 1'b1;
                        r_wb_wr_en <= r_reg_wr_en;
                        r_wb_rd    <= r_rd;
                        r_wb_data  <= w_load_data;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_MEM_ready     = (r_state == S_IDLE);
    assign o_MEM_stall     = !o_MEM_ready;
    assign o_dmem_req      = (r_state == S_REQ);
    assign o_dmem_wr_en    = o_dmem_req && r_mem_wr_en;
    assign o_dmem_addr     = {r_alu_out[XLEN-1:2], 2'b00};
    assign o_dmem_wdata    = w_wdata;
    assign o_dmem_be       = o_dmem_req ? byte_en(r_funct3, r_mem_wr_en, r_alu_out[1:0]) : 4'b0000;
    assign o_MEM_valid     = r_valid;
    assign o_MEM_reg_wr_en = r_wb_wr_en;
    assign o_MEM_rd        = r_wb_rd;
    assign o_MEM_rd_data   = r_wb_data;
    assign o_MEM_misalign  = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_riscv_mem.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_mem
//  Purpose  : Directed self-checking bench for the riscv_mem MEM stage.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_mem;

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic        ready;
    logic        reg_wr_en;
    logic [1:0]  src_rd;
    logic        mem_wr_en;
    logic [2:0]  funct3;
    logic [31:0] alu_out;
    logic [31:0] fwd_b;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic        dmem_req;
    logic        dmem_wr_en;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        out_valid;
    logic        out_wr_en;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic        misalign;
    logic        stall;

    int errors = 0;
    int checks = 0;
    int req_cycles;

    riscv_mem #(.XLEN(32)) dut (
        .i_clk           (clk),
        .i_rstn          (rstn),
        .i_MEM_valid     (in_valid),
        .o_MEM_ready     (ready),
        .i_MEM_reg_wr_en (reg_wr_en),
        .i_MEM_src_rd    (src_rd),
        .i_MEM_mem_wr_en (mem_wr_en),
        .i_MEM_funct3    (funct3),
        .i_MEM_alu_out   (alu_out),
        .i_MEM_fwd_b     (fwd_b),
        .i_MEM_imm       (imm),
        .i_MEM_pc4       (pc4),
        .i_MEM_rd        (rd),
        .o_dmem_req      (dmem_req),
        .o_dmem_wr_en    (dmem_wr_en),
        .o_dmem_addr     (dmem_addr),
        .o_dmem_wdata    (dmem_wdata),
        .o_dmem_be       (dmem_be),
        .i_dmem_gnt      (dmem_gnt),
        .i_dmem_rvalid   (dmem_rvalid),
        .i_dmem_rdata    (dmem_rdata),
        .o_MEM_valid     (out_valid),
        .o_MEM_reg_wr_en (out_wr_en),
        .o_MEM_rd        (out_rd),
        .o_MEM_rd_data   (out_data),
        .o_MEM_misalign  (misalign),
        .o_MEM_stall     (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [1:0] src, input logic st,
                         input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data, input logic [4:0] dst);
        in_valid  = 1'b1;
        reg_wr_en = wr;
        src_rd    = src;
        mem_wr_en = st;
        funct3    = f3;
        alu_out   = addr;
        fwd_b     = data;
        rd        = dst;
    endtask

    initial begin
        rstn = 1'b0; in_valid = 1'b0; reg_wr_en = 1'b0; src_rd = 2'b00;
        mem_wr_en = 1'b0; funct3 = 3'b000; alu_out = '0; fwd_b = '0;
        imm = 32'h0000_0ABC; pc4 = 32'h0000_0044; rd = 5'd0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;

        // Reset state
        tick(); tick();
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_req", {31'd0, dmem_req}, 32'd0);
        check("rst_rd_data", out_data, 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        rstn = 1'b1;
        tick();

        // ALU op, latency 1
        issue(1'b1, 2'b00, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5);
        tick();
        in_valid = 1'b0;
        check("add_valid", {31'd0, out_valid}, 32'd1);
        check("add_rd", {27'd0, out_rd}, 32'd5);
        check("add_data", out_data, 32'h0000_1234);
        check("add_wr_en", {31'd0, out_wr_en}, 32'd1);
        check("add_ready", {31'd0, ready}, 32'd1);
        tick();
        check("add_pulse_end", {31'd0, out_valid}, 32'd0);

        // SB to 0x103, grant after 3 waiting cycles
        issue(1'b0, 2'b00, 1'b1, 3'b000, 32'h0000_0103, 32'h1234_56AB, 5'd0);
        tick();
        in_valid = 1'b0;
        check("sb_be", {28'd0, dmem_be}, 32'h8);
        check("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
        check("sb_addr", dmem_addr, 32'h0000_0100);
        check("sb_wr_en", {31'd0, dmem_wr_en}, 32'd1);
        check("sb_stall", {31'd0, stall}, 32'd1);
        req_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            if (dmem_req) req_cycles++;
            check("sb_no_valid_wait", {31'd0, out_valid}, 32'd0);
            tick();
        end
        dmem_gnt = 1'b1;
        if (dmem_req) req_cycles++;
        check("sb_be_held", {28'd0, dmem_be}, 32'h8);
        tick();
        dmem_gnt = 1'b0;
        check("sb_req_cycles", req_cycles, 32'd4);
        check("sb_valid", {31'd0, out_valid}, 32'd1);
        check("sb_wr_en_wb", {31'd0, out_wr_en}, 32'd0);
        check("sb_req_drop", {31'd0, dmem_req}, 32'd0);
        tick();
        check("sb_pulse_end", {31'd0, out_valid}, 32'd0);

        // LB from 0x102, rvalid in gnt cycle ignored, real rvalid 2 cycles later
        issue(1'b1, 2'b01, 1'b0, 3'b000, 32'h0000_0102, 32'h0, 5'd7);
        tick();
        in_valid = 1'b0;
        check("lb_be", {28'd0, dmem_be}, 32'hF);
        check("lb_wr_en", {31'd0, dmem_wr_en}, 32'd0);
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_1111;
        tick();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        check("lb_wait_stall", {31'd0, stall}, 32'd1);
        check("lb_wait_no_valid", {31'd0, out_valid}, 32'd0);
        tick();
        dmem_rvalid = 1'b1; dmem_rdata = 32'h0080_0000;
        tick();
        dmem_rvalid = 1'b0;
        check("lb_valid", {31'd0, out_valid}, 32'd1);
        check("lb_data", out_data, 32'hFFFF_FF80);
        check("lb_rd", {27'd0, out_rd}, 32'd7);
        check("lb_wr_en_wb", {31'd0, out_wr_en}, 32'd1);

        // LBU, same address, immediate handshake
        issue(1'b1, 2'b01, 1'b0, 3'b100, 32'h0000_0102, 32'h0, 5'd8);
        tick();
        in_valid = 1'b0;
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h0080_0000;
        tick();
        dmem_rvalid = 1'b0;
        check("lbu_valid", {31'd0, out_valid}, 32'd1);
        check("lbu_data", out_data, 32'h0000_0080);

        // Misaligned LW at 0x106
        issue(1'b1, 2'b01, 1'b0, 3'b010, 32'h0000_0106, 32'h0, 5'd9);
        tick();
        in_valid = 1'b0;
        check("mis_req", {31'd0, dmem_req}, 32'd0);
        check("mis_valid", {31'd0, out_valid}, 32'd1);
        check("mis_flag", {31'd0, misalign}, 32'd1);
        check("mis_wr_en", {31'd0, out_wr_en}, 32'd0);
        check("mis_ready", {31'd0, ready}, 32'd1);
        tick();
        check("mis_flag_end", {31'd0, misalign}, 32'd0);

        // Reset while waiting for load data, then a late rvalid
        issue(1'b1, 2'b01, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 5'd10);
        tick();
        in_valid = 1'b0;
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        check("rstw_in_wait", {31'd0, stall}, 32'd1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("rstw_ready", {31'd0, ready}, 32'd1);
        dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        tick();
        dmem_rvalid = 1'b0;
        check("rstw_late_rvalid", {31'd0, out_valid}, 32'd0);
        tick();
        check("rstw_late_rvalid2", {31'd0, out_valid}, 32'd0);

        // Back-to-back: PC+4 writeback, SW, LH
        issue(1'b1, 2'b10, 1'b0, 3'b000, 32'h0000_0000, 32'h0, 5'd1);
        tick();
        check("b2b_alu_valid", {31'd0, out_valid}, 32'd1);
        check("b2b_alu_data", out_data, 32'h0000_0044);
        issue(1'b0, 2'b00, 1'b1, 3'b010, 32'h0000_0204, 32'hDEAD_BEEF, 5'd0);
        dmem_gnt = 1'b1;
        tick();
        in_valid = 1'b0;
        check("b2b_sw_req", {31'd0, dmem_req}, 32'd1);
        check("b2b_sw_be", {28'd0, dmem_be}, 32'hF);
        check("b2b_sw_wdata", dmem_wdata, 32'hDEAD_BEEF);
        check("b2b_sw_stall", {31'd0, stall}, 32'd1);
        check("b2b_sw_no_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check("b2b_sw_valid", {31'd0, out_valid}, 32'd1);
        check("b2b_sw_wr_en", {31'd0, out_wr_en}, 32'd0);
        check("b2b_sw_stall_end", {31'd0, stall}, 32'd0);
        issue(1'b1, 2'b01, 1'b0, 3'b001, 32'h0000_0206, 32'h0, 5'd3);
        tick();
        in_valid = 1'b0;
        check("b2b_lh_stall", {31'd0, stall}, 32'd1);
        check("b2b_lh_addr", dmem_addr, 32'h0000_0204);
        tick();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h8001_0000;
        check("b2b_lh_wait", {31'd0, stall}, 32'd1);
        tick();
        dmem_rvalid = 1'b0;
        check("b2b_lh_valid", {31'd0, out_valid}, 32'd1);
        check("b2b_lh_data", out_data, 32'hFFFF_8001);
        check("b2b_lh_rd", {27'd0, out_rd}, 32'd3);
        check("b2b_lh_stall_end", {31'd0, stall}, 32'd0);
        tick();
        check("b2b_idle", {31'd0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
